// File: rtl/alu_ctrl_pkg.sv
// ALU control codes, select constants and sequencer states.
// Shared by the decoder and the op sequencer.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_R    = 2'b00;
  localparam logic [1:0] ALUOP_BEQ  = 2'b01;
  localparam logic [1:0] ALUOP_MEM  = 2'b10;
  localparam logic [1:0] ALUOP_XORI = 2'b11;

  localparam int FUNCT_ADD = 0;
  localparam int FUNCT_SLL = 1;
  localparam int FUNCT_SUB = 2;
  localparam int FUNCT_MUL = 4;
  localparam int FUNCT_SLT = 5;

  localparam logic [3:0] SEL_ADD = 4'd0;
  localparam logic [3:0] SEL_SUB = 4'd1;
  localparam logic [3:0] SEL_MUL = 4'd2;
  localparam logic [3:0] SEL_SLT = 4'd3;
  localparam logic [3:0] SEL_SLL = 4'd4;
  localparam logic [3:0] SEL_XOR = 4'd6;
  localparam logic [3:0] SEL_NOP = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Decode-to-EX handshake bundle for the op sequencer.
// master drives ops and out_ready; slave is the sequencer.
interface alu_op_sequencer_if #(
  parameter int FUNCT_W = 6,
  parameter int SEL_W   = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         alu_op;
  logic [FUNCT_W-1:0] funct;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   sel_signal;
  logic               illegal;
  logic               busy;

  modport master (
    output in_valid,
    output alu_op,
    output funct,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sel_signal,
    input  illegal,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  alu_op,
    input  funct,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sel_signal,
    output illegal,
    output busy
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational {alu_op, funct} to ALU select decode.
// Unknown encodings map to the all-ones NOP select, never X.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W    = 6,
  parameter int SEL_W      = 4,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic [1:0]         i_alu_op,
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_illegal,
  output logic               o_is_multi
);

  logic w_rtype;
  logic w_add;
  logic w_sub;
  logic w_mul;
  logic w_slt;
  logic w_sll;

  assign w_rtype = (i_alu_op == ALUOP_R);
  assign w_add = w_rtype && (i_funct == FUNCT_W'(FUNCT_ADD));
  assign w_sub = w_rtype && (i_funct == FUNCT_W'(FUNCT_SUB));
  assign w_slt = w_rtype && (i_funct == FUNCT_W'(FUNCT_SLT));
  assign w_sll = w_rtype && (i_funct == FUNCT_W'(FUNCT_SLL));
  assign w_mul = w_rtype && ENABLE_MUL
              && (i_funct == FUNCT_W'(FUNCT_MUL));

  // One-hot select of the op class; fallthrough is illegal.
  always_comb begin
    o_sel      = '1;
    o_illegal  = 1'b1;
    o_is_multi = 1'b0;
    unique case (1'b1)
      (i_alu_op == ALUOP_BEQ): begin
        o_sel     = SEL_W'(SEL_SUB);
        o_illegal = 1'b0;
      end
      (i_alu_op == ALUOP_MEM): begin
        o_sel     = SEL_W'(SEL_ADD);
        o_illegal = 1'b0;
      end
      (i_alu_op == ALUOP_XORI): begin
        o_sel     = SEL_W'(SEL_XOR);
        o_illegal = 1'b0;
      end
      w_add: begin
        o_sel     = SEL_W'(SEL_ADD);
        o_illegal = 1'b0;
      end
      w_sub: begin
        o_sel     = SEL_W'(SEL_SUB);
        o_illegal = 1'b0;
      end
      w_mul: begin
        o_sel      = SEL_W'(SEL_MUL);
        o_illegal  = 1'b0;
        o_is_multi = 1'b1;
      end
      w_slt: begin
        o_sel     = SEL_W'(SEL_SLT);
        o_illegal = 1'b0;
      end
      w_sll: begin
        o_sel     = SEL_W'(SEL_SLL);
        o_illegal = 1'b0;
      end
      default: begin
        o_sel      = '1;
        o_illegal  = 1'b1;
        o_is_multi = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered, handshaked ALU control: decode, MUL sequencing,
// and output hold under EX backpressure.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W    = 6,
  parameter int SEL_W      = 4,
  parameter int MUL_CYCLES = 4,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_op_sequencer_if.slave bus
);

  localparam int CNT_W    = $clog2(MUL_CYCLES) + 1;
  localparam int CNT_INIT = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
  localparam bit MULTI_EN = (MUL_CYCLES > 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_illegal;
  logic             r_out_valid;
  logic             r_busy;

  logic [SEL_W-1:0] w_dec_sel;
  logic             w_dec_illegal;
  logic             w_dec_multi;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_go_exec;

  alu_ctrl_decode #(
    .FUNCT_W    (FUNCT_W),
    .SEL_W      (SEL_W),
    .ENABLE_MUL (ENABLE_MUL)
  ) u_decode (
    .i_alu_op   (bus.alu_op),
    .i_funct    (bus.funct),
    .o_sel      (w_dec_sel),
    .o_illegal  (w_dec_illegal),
    .o_is_multi (w_dec_multi)
  );

  // HOLD accepts only when EX drains the current result this cycle.
  assign w_in_ready = rst_n
                   && ((r_state == ST_IDLE)
                   || ((r_state == ST_HOLD) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_go_exec  = w_dec_multi && MULTI_EN;

  // Sequencer FSM with registered select, flags and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            r_sel     <= w_dec_sel;
            r_illegal <= w_dec_illegal;
            if (w_go_exec) begin
              r_state     <= ST_EXEC;
              r_cnt       <= CNT_W'(CNT_INIT);
              r_out_valid <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
              r_busy      <= 1'b0;
            end
          end else if ((r_state == ST_HOLD) && bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.sel_signal = r_sel;
  assign bus.illegal    = r_illegal;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a cycle-level
// reference model and a per-cycle compare process.
module tb_alu_op_sequencer;

  localparam int MULC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] funct = 6'd0;

  int n_total = 0;
  int n_bad   = 0;

  alu_op_sequencer_if #(.FUNCT_W(6), .SEL_W(4)) bus0 ();
  alu_op_sequencer_if #(.FUNCT_W(6), .SEL_W(4)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.alu_op    = alu_op;
  assign bus0.funct     = funct;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.alu_op    = alu_op;
  assign bus1.funct     = funct;
  assign bus1.out_ready = out_ready;

  alu_op_sequencer #(
    .FUNCT_W(6), .SEL_W(4), .MUL_CYCLES(MULC), .ENABLE_MUL(1'b1)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  alu_op_sequencer #(
    .FUNCT_W(6), .SEL_W(4), .MUL_CYCLES(MULC), .ENABLE_MUL(1'b0)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Decode table straight from the op list.
  function automatic void spec_dec(input logic [1:0] op, input int f,
                                   input bit en, output int sel,
                                   output bit ill, output bit mul);
    ill = 1'b0;
    mul = 1'b0;
    sel = 15;
    case (op)
      2'b01: sel = 1;
      2'b10: sel = 0;
      2'b11: sel = 6;
      default: begin
        case (f)
          0: sel = 0;
          2: sel = 1;
          5: sel = 3;
          1: sel = 4;
          4: begin
            if (en) begin
              sel = 2;
              mul = 1'b1;
            end else begin
              ill = 1'b1;
            end
          end
          default: ill = 1'b1;
        endcase
      end
    endcase
  endfunction

  // Model: one pending result, cycles-until-valid countdown.
  bit m_run  = 1'b0;
  bit m_have = 1'b0;
  int m_left = 0;
  int m_sel  = 0;
  bit m_ill  = 1'b0;

  always @(posedge clk) begin
    bit v;
    bit acc;
    int s;
    bit il;
    bit mu;
    if (!rst_n) begin
      m_have = 1'b0;
      m_left = 0;
      m_sel  = 0;
      m_ill  = 1'b0;
      m_run  = 1'b1;
    end else begin
      v   = m_have && (m_left == 0);
      acc = in_valid && (!m_have || (v && out_ready));
      if (m_have && m_left > 0) m_left--;
      else if (v && out_ready) m_have = 1'b0;
      if (acc) begin
        spec_dec(alu_op, int'(funct), 1'b1, s, il, mu);
        m_have = 1'b1;
        m_sel  = s;
        m_ill  = il;
        m_left = (mu && MULC > 1) ? MULC - 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    bit eb;
    bit er;
    if (m_run) begin
      ev = m_have && (m_left == 0);
      eb = m_have && (m_left > 0);
      er = rst_n && (!m_have || (ev && out_ready));
      cmp("m_out_valid", 32'(bus0.out_valid), 32'(ev));
      cmp("m_busy", 32'(bus0.busy), 32'(eb));
      cmp("m_in_ready", 32'(bus0.in_ready), 32'(er));
      if (ev || eb) begin
        cmp("m_sel", 32'(bus0.sel_signal), 32'(m_sel));
        cmp("m_illegal", 32'(bus0.illegal), 32'(m_ill));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int fl[4] = '{0, 2, 5, 1};
  int el[4] = '{0, 1, 3, 4};

  initial begin
    // Reset with a pending op on the input.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (2) step();
    cmp("rst_valid", 32'(bus0.out_valid), 32'd0);
    cmp("rst_sel", 32'(bus0.sel_signal), 32'd0);
    cmp("rst_in_ready", 32'(bus0.in_ready), 32'd0);
    cmp("rst_busy", 32'(bus0.busy), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    cmp("post_rst_ready", 32'(bus0.in_ready), 32'd1);
    step();

    // Back-to-back single-cycle stream.
    for (int k = 0; k < 4; k++) begin
      alu_op   = 2'b00;
      funct    = 6'(fl[k]);
      in_valid = 1'b1;
      step();
      cmp("stream_valid", 32'(bus0.out_valid), 32'd1);
      cmp("stream_sel", 32'(bus0.sel_signal), 32'(el[k]));
      cmp("stream_ready", 32'(bus0.in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    cmp("stream_drain", 32'(bus0.out_valid), 32'd0);

    // MUL: three busy cycles, result on the fourth.
    funct    = 6'd4;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmp("mul_busy", 32'(bus0.busy), 32'd1);
      cmp("mul_ready", 32'(bus0.in_ready), 32'd0);
      cmp("mul_valid", 32'(bus0.out_valid), 32'd0);
      step();
    end
    cmp("mul_done", 32'(bus0.out_valid), 32'd1);
    cmp("mul_sel", 32'(bus0.sel_signal), 32'd2);
    cmp("mul_busy_end", 32'(bus0.busy), 32'd0);
    step();

    // Backpressure on xori with toggling inputs.
    alu_op    = 2'b11;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      cmp("bp_sel", 32'(bus0.sel_signal), 32'd6);
      cmp("bp_ready", 32'(bus0.in_ready), 32'd0);
      cmp("bp_valid", 32'(bus0.out_valid), 32'd1);
      in_valid = ~in_valid;
      alu_op   = 2'(i);
      funct    = 6'(i + 3);
      step();
    end
    cmp("bp_sel_end", 32'(bus0.sel_signal), 32'd6);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    cmp("bp_release", 32'(bus0.out_valid), 32'd0);

    // Illegal funct.
    alu_op   = 2'b00;
    funct    = 6'd7;
    in_valid = 1'b1;
    step();
    cmp("ill_valid", 32'(bus0.out_valid), 32'd1);
    cmp("ill_flag", 32'(bus0.illegal), 32'd1);
    cmp("ill_sel", 32'(bus0.sel_signal), 32'hF);
    in_valid = 1'b0;
    repeat (2) step();

    // MUL with multiply disabled, then reset mid-EXEC.
    funct    = 6'd4;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cmp("nomul_valid", 32'(bus1.out_valid), 32'd1);
    cmp("nomul_flag", 32'(bus1.illegal), 32'd1);
    cmp("nomul_sel", 32'(bus1.sel_signal), 32'hF);
    cmp("nomul_busy", 32'(bus1.busy), 32'd0);
    cmp("mid_busy", 32'(bus0.busy), 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    cmp("mid_rst_ready", 32'(bus0.in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    cmp("mid_rst_busy", 32'(bus0.busy), 32'd0);
    cmp("mid_rst_valid", 32'(bus0.out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      cmp("mid_dropped", 32'(bus0.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
